// File: rtl/soc_pkg.sv
// soc_pkg: shared run-status/trace types, tohost defaults and the tiny core's instruction encoding
// Contents: run_status_e (RUN/PASS/FAIL/TIMEOUT), trace_entry_t {addr,data},
// TOHOST_ADDR/PASS_VALUE defaults, instruction word layout {op[1:0], imm[7:0]}.
package soc_pkg;
    typedef enum logic [1:0] {RUN = 2'b00, PASS = 2'b01, FAIL = 2'b10, TIMEOUT = 2'b11} run_status_e;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0064;
    localparam logic [31:0] PASS_VALUE_DEFAULT  = 32'd7;
    localparam int IW         = 10;
    localparam int IMEM_WORDS = 32;
    localparam int PC_WIDTH   = $clog2(IMEM_WORDS);
    localparam logic [1:0] OP_LI = 2'd0, OP_ADDI = 2'd1, OP_SW = 2'd2, OP_J = 2'd3;
    localparam logic [IMEM_WORDS*IW-1:0] DEFAULT_PROGRAM = '0;
endpackage

// File: rtl/mother_board.sv
// mother_board: single-cycle accumulator core with an instruction fetch port and a dmem store port
// Ports: clk, reset (sync, active-high); imem_addr out (PC), imem_data in (instruction);
// dmem_addr/dmem_wdata/dmem_we out (store bus). Ops: LI acc=imm, ADDI acc+=imm, SW [imm]=acc, J pc=imm.
module mother_board
    import soc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [IW-1:0]         imem_data,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_we
);
    logic [1:0]            op;
    logic [7:0]            imm;
    logic [DATA_WIDTH-1:0] acc;

    assign op         = imem_data[IW-1 -: 2];
    assign imm        = imem_data[7:0];
    assign dmem_we    = op == OP_SW;
    assign dmem_addr  = ADDR_WIDTH'(imm);
    assign dmem_wdata = acc;

    always_ff @(posedge clk)
        if (reset) begin
            imem_addr <= '0;
            acc       <= '0;
        end else begin
            imem_addr <= op == OP_J ? imm[PC_WIDTH-1:0] : imem_addr + 1'b1;
            acc       <= op == OP_LI ? DATA_WIDTH'(imm) : op == OP_ADDI ? acc + DATA_WIDTH'(imm) : acc;
        end
endmodule

// File: rtl/soc_store_trace_fifo.sv
// store_trace_fifo: circular store-trace buffer keeping the most recent DEPTH entries
// Ports: clk, reset (sync, active-high); push/din write an entry; pop removes the oldest;
// dout is the oldest entry, valid while non-empty. Built only when STORE_TRACE_EN is defined.
`ifdef STORE_TRACE_EN
module store_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             adv;

    assign valid = count != '0;
    // a push into a full buffer also advances the read side, dropping the oldest entry
    assign adv   = (pop & valid) | (push & (count == (PW+1)'(DEPTH)));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (adv)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(adv);
        end
endmodule
`endif

// File: rtl/soc_top.sv
// soc_top: core wrapper with tohost pass/fail detection, watchdog, cycle/store counters and halt freeze
// Ports: clk, reset (sync, active-high); write_data/data_addr/write_enab dmem store bus (strobe
// forced 0 while halted); halted; status 00 RUN/01 PASS/10 FAIL/11 TIMEOUT; cycle_count;
// store_count; trace_pop in, trace_valid/trace_data out ({addr,data} of oldest traced store).
// Macro STORE_TRACE_EN adds the store-trace FIFO; without it trace_valid/trace_data read 0.
module soc_top
    import soc_pkg::*;
#(
    parameter int                       ADDR_WIDTH     = 32,
    parameter int                       DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]    TOHOST_ADDR    = ADDR_WIDTH'(TOHOST_ADDR_DEFAULT),
    parameter logic [DATA_WIDTH-1:0]    PASS_VALUE     = DATA_WIDTH'(PASS_VALUE_DEFAULT),
    parameter int                       TIMEOUT_CYCLES = 1000,
    parameter int                       CNT_WIDTH      = 32,
    parameter int                       TRACE_DEPTH    = 8,
    parameter logic [IMEM_WORDS*IW-1:0] PROGRAM        = DEFAULT_PROGRAM
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic [ADDR_WIDTH-1:0]            data_addr,
    output logic                             write_enab,
    output logic                             halted,
    output logic [1:0]                       status,
    output logic [CNT_WIDTH-1:0]             cycle_count,
    output logic [CNT_WIDTH-1:0]             store_count,
    input  logic                             trace_pop,
    output logic                             trace_valid,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] trace_data
);
    run_status_e           status_q, status_d;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [IW-1:0]         imem_data;
    logic                  core_we, st, tohost, timeout;

    assign imem_data = PROGRAM[imem_addr*IW +: IW];

    // a halted core is held in reset so it cannot issue further stores
    mother_board #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_board (
        .clk        (clk),
        .reset      (reset | halted),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (data_addr),
        .dmem_wdata (write_data),
        .dmem_we    (core_we)
    );

    assign st      = write_enab;
    assign tohost  = st && data_addr == TOHOST_ADDR;
    assign timeout = TIMEOUT_CYCLES != 0 && cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk)
        if (reset) begin
            status_q <= RUN;
            halted   <= 1'b0;
        end else begin
            status_q <= status_d;
            halted   <= status_d != RUN;
        end

    // a tohost store outranks a watchdog expiry in the same cycle
    always_comb begin
        status_d = status_q;
        if (status_q == RUN)
            status_d = tohost ? (write_data == PASS_VALUE ? PASS : FAIL) : timeout ? TIMEOUT : RUN;
    end

    always_comb begin
        status     = status_q;
        write_enab = core_we & ~halted;
    end

    always_ff @(posedge clk)
        if (reset) begin
            cycle_count <= '0;
            store_count <= '0;
        end else begin
            if (status_q == RUN && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
            if (st && store_count != '1)
                store_count <= store_count + 1'b1;
        end

`ifdef STORE_TRACE_EN
    store_trace_fifo #(.DEPTH(TRACE_DEPTH), .WIDTH(ADDR_WIDTH + DATA_WIDTH)) u_trace (
        .clk   (clk),
        .reset (reset),
        .push  (st),
        .pop   (trace_pop),
        .din   ({data_addr, write_data}),
        .dout  (trace_data),
        .valid (trace_valid)
    );
`else
    logic unused_trace_pop;
    assign unused_trace_pop = trace_pop;
    assign trace_valid      = 1'b0;
    assign trace_data       = '0;
`endif
endmodule
